output_writer: RTL and testbench
================================

Name: output_writer

Overview:
- AXI write initiator that drains PE-array results to external memory; the write-side counterpart of the input buffer's AXI read path.
- Accepts one output row segment of POX words per handshake and buffers up to two segments (ping-pong).
- Writes each segment as one INCR burst, walking the output map in POY-row x POX-column tiles.
- Flags block and map completion, and reports write-response errors.

Parameters:
- DW, 32, data and word width.
- AW, 32, address width; addresses are word-granular (one unit = one DW word).
- POX, 15, words per segment = burst length; 1..256.
- POY, 3, segment rows per tile.
- OW, 105, output map width in words; must be a multiple of POX.
- OH, 105, output map height in rows; must be a multiple of POY.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- init_addr_en  in  1  load map base address.
- init_addr  in  AW  map base address.
- res_valid  in  1  result segment valid.
- res_ready  out  1  segment slot free.
- res_data  in  POX*DW  segment; word 0 in bits [DW-1:0].
- awvalid  out  1  write address valid.
- awready  in  1  write address ready.
- awaddr  out  AW  burst start address.
- awlen  out  8  burst length minus 1; constant POX-1.
- awburst  out  2  constant 2'b01 (INCR).
- wvalid  out  1  write data valid.
- wready  in  1  write data ready.
- wdata  out  DW  write data.
- wlast  out  1  last beat of burst.
- bvalid  in  1  write response valid.
- bready  out  1  write response ready.
- bresp  in  2  write response code.
- blkdone  out  1  one-cycle pulse: tile complete.
- mapend  out  1  one-cycle pulse: map complete.
- err  out  1  sticky: non-OKAY response received.

Behaviour:
- Reset: all outputs 0, except res_ready=1, awlen=POX-1, awburst=1. Buffer empty; counters r, bx, by, beat = 0; base = 0; FSM = IDLE. Reset mid-burst abandons the burst with no completion.
- Buffer:
  - Two slots; res_ready = (slots used < 2).
  - Push on res_valid & res_ready. Pop on the final B handshake of a segment.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
- Addressing: awaddr = base + (by*POY + r)*OW + bx*POX, computed in AW bits and wrapping modulo 2^AW.
- FSM:
  - IDLE: when a slot is occupied, go to ADDR; awvalid rises the cycle after the push at the earliest.
  - ADDR: hold awvalid and awaddr stable until awready; then go to DATA with beat=0. AW never retracts.
  - DATA: wvalid=1 and wdata = word[beat] of the head slot. beat increments on wready. wlast=1 when beat==POX-1; on that handshake go to RESP. wvalid and wdata are held stable while wready is low. W is never issued before AW is accepted.
  - RESP: bready=1. On bvalid, set err if bresp != 0, then pop. Go to IDLE, or straight to ADDR if another slot is occupied, giving zero idle cycles between bursts. Only one burst is outstanding at a time.
- Tile walk, advanced on each B handshake:
  - r increments.
  - At r==POY-1: r=0, pulse blkdone, bx increments.
  - At bx==OW/POX-1: bx=0, by increments.
  - At by==OH/POY-1: by=0, pulse mapend, base += OW*OH so the next map follows contiguously.
  - blkdone and mapend pulse in the same cycle on the final tile.
- init_addr_en:
  - Honoured only in IDLE with the buffer empty: base=init_addr, counters zeroed, err cleared.
  - Otherwise ignored, with no effect on an in-flight burst.
  - If it coincides with a push in IDLE, the load takes effect first and the pushed segment uses the new base.
- Error policy: a non-OKAY response does not stop operation; the segment is popped and counters advance.

Test Plan:
- Reset, init_addr=0x100, push one segment with word i = i+1 -> awaddr=0x100, awlen=14, 15 beats of 1..15, wlast on beat 15; after B, res_ready=1 and no blkdone.
- Push 3 segments back-to-back -> awaddr 0x100, 0x169, 0x1D2; blkdone after the third B; res_ready drops while 2 slots are full; no idle cycle between bursts.
- Continue to tile 2 -> first awaddr=0x10F; after 7 tiles (bx wrap) -> awaddr=0x23B.
- Stream 735 segments -> 245 blkdone pulses, mapend once coincident with the last blkdone; next segment awaddr=0x2C11.
- Backpressure: awready low for 5 cycles and wready toggling every cycle -> awaddr, wdata and wvalid stable while stalled; no beat lost or duplicated.
- bresp=2'b10 on one burst -> err=1 and stays set; the next burst proceeds; init_addr_en in IDLE with empty buffer clears err. Reset asserted mid-DATA -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/output_writer_if.sv
// Result-segment intake plus AXI write-address/data/response channels of the output writer.
// The writer sits on the master side; the PE array and the memory sit on the slave side.
interface output_writer_if #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int POX = 15
);
  logic              res_valid;
  logic              res_ready;
  logic [POX*DW-1:0] res_data;
  logic              awvalid;
  logic              awready;
  logic [AW-1:0]     awaddr;
  logic [7:0]        awlen;
  logic [1:0]        awburst;
  logic              wvalid;
  logic              wready;
  logic [DW-1:0]     wdata;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  modport master (
    input  res_valid, res_data, awready, wready, bvalid, bresp,
    output res_ready, awvalid, awaddr, awlen, awburst, wvalid, wdata, wlast, bready
  );

  modport slave (
    output res_valid, res_data, awready, wready, bvalid, bresp,
    input  res_ready, awvalid, awaddr, awlen, awburst, wvalid, wdata, wlast, bready
  );
endinterface

// File: rtl/output_writer.sv
// AXI write initiator: buffers two POX-word result segments and writes each as one INCR
// burst, walking the output map in POY-row x POX-column tiles.
module output_writer #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int POX = 15,
  parameter int POY = 3,
  parameter int OW  = 105,
  parameter int OH  = 105
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_addr_en,
  input  logic [AW-1:0]       init_addr,
  output_writer_if.master     bus,
  output logic                blkdone,
  output logic                mapend,
  output logic                err
);
  localparam int NBX = OW / POX;
  localparam int NBY = OH / POY;
  localparam int RW  = (POY > 1) ? $clog2(POY) : 1;
  localparam int BXW = (NBX > 1) ? $clog2(NBX) : 1;
  localparam int BYW = (NBY > 1) ? $clog2(NBY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            state_r;
  logic [POX*DW-1:0] slot_r [2];
  logic              head_r;
  logic [1:0]        count_r;
  logic [1:0]        count_n_s;
  logic              res_ready_r, awvalid_r, wvalid_r, wlast_r, bready_r;
  logic              blkdone_r, mapend_r, err_r;
  logic [AW-1:0]     awaddr_r, base_r, base_n_s, addr_s;
  logic [DW-1:0]     wdata_r;
  logic [7:0]        beat_r, beat_nx_s;
  logic [RW-1:0]     r_r, r_n_s;
  logic [BXW-1:0]    bx_r, bx_n_s;
  logic [BYW-1:0]    by_r, by_n_s;
  logic              push_s, pop_s, load_s, blk_s, map_s;
  logic [POX*DW-1:0] head_seg_s;

  assign push_s     = bus.res_valid & res_ready_r;
  assign pop_s      = (state_r == S_RESP) & bus.bvalid & bready_r;
  assign load_s     = init_addr_en & (state_r == S_IDLE) & (count_r == 2'd0);
  assign head_seg_s = slot_r[head_r];
  assign beat_nx_s  = beat_r + 8'd1;
  // Addresses use the post-update counters so a burst launched on the B handshake is already advanced.
  assign addr_s = base_n_s + ((AW'(by_n_s) * AW'(POY)) + AW'(r_n_s)) * AW'(OW)
                + AW'(bx_n_s) * AW'(POX);

  assign bus.res_ready = res_ready_r;
  assign bus.awvalid   = awvalid_r;
  assign bus.awaddr    = awaddr_r;
  assign bus.awlen     = 8'(POX - 1);
  assign bus.awburst   = 2'b01;
  assign bus.wvalid    = wvalid_r;
  assign bus.wdata     = wdata_r;
  assign bus.wlast     = wlast_r;
  assign bus.bready    = bready_r;
  assign blkdone       = blkdone_r;
  assign mapend        = mapend_r;
  assign err           = err_r;

  // Slot occupancy after this cycle's push/pop.
  always_comb begin
    count_n_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_n_s = count_r + 2'd1;
      2'b01:   count_n_s = count_r - 2'd1;
      default: count_n_s = count_r;
    endcase
  end

  // Next tile-walk position: a base load wins, otherwise advance one row per retired segment.
  always_comb begin
    r_n_s    = r_r;
    bx_n_s   = bx_r;
    by_n_s   = by_r;
    base_n_s = base_r;
    blk_s    = 1'b0;
    map_s    = 1'b0;
    if (load_s) begin
      r_n_s    = {RW{1'b0}};
      bx_n_s   = {BXW{1'b0}};
      by_n_s   = {BYW{1'b0}};
      base_n_s = init_addr;
    end else if (pop_s) begin
      if (r_r == RW'(POY - 1)) begin
        r_n_s = {RW{1'b0}};
        blk_s = 1'b1;
        if (bx_r == BXW'(NBX - 1)) begin
          bx_n_s = {BXW{1'b0}};
          if (by_r == BYW'(NBY - 1)) begin
            by_n_s   = {BYW{1'b0}};
            map_s    = 1'b1;
            base_n_s = base_r + AW'(OW * OH);
          end else begin
            by_n_s = by_r + BYW'(1);
          end
        end else begin
          bx_n_s = bx_r + BXW'(1);
        end
      end else begin
        r_n_s = r_r + RW'(1);
      end
    end else begin
      base_n_s = base_r;
    end
  end

  // Ping-pong segment storage; the tail slot is the one after the head when one is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_r[0]   <= '0;
      slot_r[1]   <= '0;
      head_r      <= 1'b0;
      count_r     <= 2'd0;
      res_ready_r <= 1'b1;
    end else begin
      if (push_s) slot_r[head_r ^ count_r[0]] <= bus.res_data;
      if (pop_s) head_r <= ~head_r;
      count_r     <= count_n_s;
      res_ready_r <= (count_n_s != 2'd2);
    end
  end

  // Burst sequencer with registered AXI outputs and tile-walk bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      awvalid_r <= 1'b0;
      awaddr_r  <= '0;
      wvalid_r  <= 1'b0;
      wdata_r   <= '0;
      wlast_r   <= 1'b0;
      bready_r  <= 1'b0;
      beat_r    <= 8'd0;
      r_r       <= '0;
      bx_r      <= '0;
      by_r      <= '0;
      base_r    <= '0;
      blkdone_r <= 1'b0;
      mapend_r  <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      r_r       <= r_n_s;
      bx_r      <= bx_n_s;
      by_r      <= by_n_s;
      base_r    <= base_n_s;
      blkdone_r <= blk_s;
      mapend_r  <= map_s;
      if (load_s) err_r <= 1'b0;
      else if (pop_s && (bus.bresp != 2'b00)) err_r <= 1'b1;
      case (state_r)
        S_IDLE: begin
          if (push_s || (count_r != 2'd0)) begin
            state_r   <= S_ADDR;
            awvalid_r <= 1'b1;
            awaddr_r  <= addr_s;
          end
        end
        S_ADDR: begin
          if (bus.awready) begin
            awvalid_r <= 1'b0;
            state_r   <= S_DATA;
            wvalid_r  <= 1'b1;
            beat_r    <= 8'd0;
            wdata_r   <= head_seg_s[DW-1:0];
            wlast_r   <= (POX == 1);
          end
        end
        S_DATA: begin
          if (bus.wready) begin
            if (wlast_r) begin
              wvalid_r <= 1'b0;
              wlast_r  <= 1'b0;
              bready_r <= 1'b1;
              state_r  <= S_RESP;
            end else begin
              beat_r  <= beat_nx_s;
              wdata_r <= head_seg_s[int'(beat_nx_s) * DW +: DW];
              wlast_r <= (beat_nx_s == 8'(POX - 1));
            end
          end
        end
        S_RESP: begin
          if (pop_s) begin
            bready_r <= 1'b0;
            if (count_n_s != 2'd0) begin
              state_r   <= S_ADDR;
              awvalid_r <= 1'b1;
              awaddr_r  <= addr_s;
            end else begin
              state_r <= S_IDLE;
            end
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_writer.sv
// Directed bench for output_writer: a memory responder records every AXI transfer and the
// main sequence checks addresses, beats, tile pulses, error flag and reset behaviour.
module tb_output_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_addr_en = 1'b0;
  logic [31:0] init_addr = 32'd0;
  logic        blkdone, mapend, err;

  output_writer_if #(.DW(32), .AW(32), .POX(15)) bus();

  output_writer #(.DW(32), .AW(32), .POX(15), .POY(3), .OW(105), .OH(105)) dut (
    .clk(clk), .rst(rst), .init_addr_en(init_addr_en), .init_addr(init_addr),
    .bus(bus), .blkdone(blkdone), .mapend(mapend), .err(err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // Responder configuration, written only by the main sequence.
  int aw_stall_cfg = 0;
  bit w_toggle = 1'b0;
  bit berr_on = 1'b0;

  // Responder observations, written only by the responder.
  int cyc = 0, last_b_cyc = 0, rise_gap = 0, stall_cnt = 0;
  int b_count = 0, blk_cnt = 0, map_cnt = 0, map_blk_at = 0, map_solo = 0;
  int stab_err = 0, rr_low_cnt = 0, aw_stall_obs = 0, w_stall_obs = 0;
  logic        p_awvalid = 1'b0, p_aw_stall = 1'b0, p_w_stall = 1'b0, p_wlast = 1'b0;
  logic [31:0] p_awaddr = 32'd0, p_wdata = 32'd0;
  logic [31:0] aw_q[$];
  int          gap_q[$];
  logic [31:0] wd_q[$];
  logic        wl_q[$];

  // Memory model: drives ready/response on the falling edge and logs every handshake.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      bus.bresp   = 2'b00;
      p_awvalid   = 1'b0;
      p_aw_stall  = 1'b0;
      p_w_stall   = 1'b0;
      stall_cnt   = 0;
    end else begin
      if (p_aw_stall && (bus.awvalid !== 1'b1 || bus.awaddr !== p_awaddr)) stab_err++;
      if (p_w_stall && (bus.wvalid !== 1'b1 || bus.wdata !== p_wdata || bus.wlast !== p_wlast))
        stab_err++;
      if (bus.awvalid && !p_awvalid) rise_gap = cyc - last_b_cyc;
      if (bus.awvalid && stall_cnt < aw_stall_cfg) begin
        bus.awready = 1'b0;
        stall_cnt++;
      end else begin
        bus.awready = 1'b1;
      end
      bus.wready = w_toggle ? !bus.wready : 1'b1;
      bus.bvalid = bus.bready;
      bus.bresp  = berr_on ? 2'b10 : 2'b00;
      if (bus.awvalid && bus.awready) begin
        aw_q.push_back(bus.awaddr);
        gap_q.push_back(rise_gap);
        stall_cnt = 0;
      end
      if (bus.awvalid && !bus.awready) aw_stall_obs++;
      if (bus.wvalid && bus.wready) begin
        wd_q.push_back(bus.wdata);
        wl_q.push_back(bus.wlast);
      end
      if (bus.wvalid && !bus.wready) w_stall_obs++;
      if (bus.bvalid && bus.bready) begin
        b_count++;
        last_b_cyc = cyc;
      end
      if (!bus.res_ready) rr_low_cnt++;
      if (blkdone) blk_cnt++;
      if (mapend) begin
        map_cnt++;
        map_blk_at = blk_cnt;
        if (!blkdone) map_solo++;
      end
      p_awvalid  = bus.awvalid;
      p_aw_stall = bus.awvalid && !bus.awready;
      p_awaddr   = bus.awaddr;
      p_w_stall  = bus.wvalid && !bus.wready;
      p_wdata    = bus.wdata;
      p_wlast    = bus.wlast;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Segment g carries words g*16+1+i.
  task automatic push(input int g);
    int n = 0;
    bus.res_valid = 1'b1;
    for (int i = 0; i < 15; i++) bus.res_data[i*32 +: 32] = 32'(g * 16 + 1 + i);
    while (bus.res_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", bus.res_ready, 1'b1);
    @(negedge clk);
    bus.res_valid = 1'b0;
  endtask

  task automatic wait_b(input int n);
    int k = 0;
    while (b_count < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("b_count", b_count, n);
    repeat (2) @(negedge clk);
  endtask

  task automatic load_base(input logic [31:0] a);
    init_addr_en = 1'b1;
    init_addr    = a;
    @(negedge clk);
    init_addr_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    chk("rst_res_ready", bus.res_ready, 1'b1);
    chk("rst_awvalid", bus.awvalid, 1'b0);
    chk("rst_awaddr", bus.awaddr, 32'd0);
    chk("rst_awlen", bus.awlen, 8'd14);
    chk("rst_awburst", bus.awburst, 2'b01);
    chk("rst_wvalid", bus.wvalid, 1'b0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_wlast", bus.wlast, 1'b0);
    chk("rst_bready", bus.bready, 1'b0);
    chk("rst_blkdone", blkdone, 1'b0);
    chk("rst_mapend", mapend, 1'b0);
    chk("rst_err", err, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, w0, bc, bk;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);

    // Single segment at base 0x100.
    load_base(32'h100);
    push(0);
    wait_b(1);
    chk("t1_awaddr", aw_q[0], 32'h100);
    chk("t1_blk", blk_cnt, 0);
    chk("t1_res_ready", bus.res_ready, 1'b1);

    // Three back-to-back segments from a fresh base: one full tile.
    load_base(32'h100);
    push(1);
    push(2);
    push(3);
    wait_b(4);
    chk("t2_addr0", aw_q[1], 32'h100);
    chk("t2_addr1", aw_q[2], 32'h169);
    chk("t2_addr2", aw_q[3], 32'h1D2);
    chk("t2_blk", blk_cnt, 1);
    chk("t2_rr_low", rr_low_cnt > 0, 1'b1);
    chk("t2_gap1", gap_q[2], 1);
    chk("t2_gap2", gap_q[3], 1);

    // Stream the rest of the map plus one segment into the next map.
    for (int g = 4; g <= 736; g++) push(g);
    wait_b(737);
    chk("t3_tile2", aw_q[4], 32'h10F);
    chk("t3_bxwrap", aw_q[22], 32'h23B);
    chk("t4_nextmap", aw_q[736], 32'h2C11);
    chk("t4_blk", blk_cnt, 245);
    chk("t4_map", map_cnt, 1);
    chk("t4_map_at_blk", map_blk_at, 245);
    chk("t4_map_solo", map_solo, 0);

    // Address stall of 5 cycles and toggling write-ready.
    s0 = aw_stall_obs;
    w0 = w_stall_obs;
    aw_stall_cfg = 5;
    w_toggle = 1'b1;
    push(737);
    wait_b(738);
    aw_stall_cfg = 0;
    w_toggle = 1'b0;
    chk("t5_awaddr", aw_q[737], 32'h2C7A);
    chk("t5_aw_stalls", aw_stall_obs - s0, 5);
    chk("t5_w_stalled", (w_stall_obs - w0) > 0, 1'b1);
    chk("t5_stable", stab_err, 0);

    // Error response is sticky, does not stop the walk, and is cleared by a base load.
    berr_on = 1'b1;
    push(738);
    wait_b(739);
    berr_on = 1'b0;
    chk("t6_err_set", err, 1'b1);
    chk("t6_blk", blk_cnt, 246);
    push(739);
    wait_b(740);
    chk("t6_err_sticky", err, 1'b1);
    chk("t6_next_addr", aw_q[739], 32'h2C20);
    load_base(32'h100);
    chk("t6_err_clear", err, 1'b0);

    // Every beat of every completed burst, in order, with wlast only on beat 15.
    chk("beat_total", wd_q.size(), 740 * 15);
    for (int g = 0; g < 740; g++) begin
      for (int i = 0; i < 15; i++) begin
        chk("wdata", wd_q[g*15 + i], 32'(g * 16 + 1 + i));
        chk("wlast", wl_q[g*15 + i], (i == 14));
      end
    end

    // Reset in the middle of a data phase.
    push(740);
    s0 = 0;
    while (bus.wvalid !== 1'b1 && s0 < 100) begin
      @(negedge clk);
      s0++;
    end
    chk("t7_in_data", bus.wvalid, 1'b1);
    repeat (3) @(negedge clk);
    bc = b_count;
    bk = blk_cnt;
    rst = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t7_idle_awvalid", bus.awvalid, 1'b0);
    chk("t7_idle_wvalid", bus.wvalid, 1'b0);
    chk("t7_no_b", b_count, bc);
    chk("t7_no_blk", blk_cnt, bk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
